dbuf_page_reader: RTL and testbench
===================================

DBUF_PAGE_READER -- requirements
Module: dbuf_page_reader

Interface
REQ-001 SHALL have parameter P_RD_ADDR_WIDTH, default 9, double-buffer read address width (words per page = 2^P_RD_ADDR_WIDTH).
REQ-002 SHALL have parameter P_DATA_WIDTH, default 64, word width.
REQ-003 SHALL have parameter P_RD_LATENCY, default 1, DPRAM read latency in clk cycles; legal values 1 and 2.
REQ-004 SHALL have ports:
- clk  in  1  clock; also drives the double-buffer rd_clk.
- rst  in  1  synchronous, active-high reset.
- rd_busy  in  1  double-buffer read-side page full flag.
- dpram_len  in  16  page length in words; valid while rd_busy=1.
- rd_addr  out  P_RD_ADDR_WIDTH  DPRAM read address.
- rd_dout  in  P_DATA_WIDTH  DPRAM read data, P_RD_LATENCY cycles after rd_addr.
- done  out  1  one-cycle pulse releasing the page.
- dout  out  P_DATA_WIDTH  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.
- dout_last  out  1  final word of page, qualified by dout_valid.
- active  out  1  page transfer in progress.

Function
REQ-005 SHALL implement FSM states S_IDLE, S_HDR, S_READ, S_DRAIN, S_DONE, S_HOLDOFF.
REQ-006 S_IDLE: when rd_busy=1, SHALL latch len = min(dpram_len, 2^P_RD_ADDR_WIDTH), clear counters, go to S_HDR if DBUF_RDR_HEADER_EN is defined, else to S_READ.
REQ-007 A word transfers only on a cycle with dout_valid=1 and dout_ready=1. dout, dout_valid and dout_last SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-008 S_READ: SHALL issue rd_addr = issue count, one address per cycle, while issue count < len and (FIFO occupancy + words in flight) < 4.
REQ-009 Returned data SHALL enter a 4-entry output FIFO exactly P_RD_LATENCY cycles after the address is issued. No word SHALL be lost or duplicated under any dout_ready pattern.
REQ-010 With dout_ready held at 1, throughput SHALL be 1 word/cycle. The first payload word SHALL be valid no later than P_RD_LATENCY+1 cycles after entering S_READ.
REQ-011 When issue count reaches len, the FSM SHALL go to S_DRAIN and stay there until the FIFO is empty and no read is in flight.
REQ-012 dout_last SHALL be 1 only on the word whose transfer brings the total transferred count to len (header included when present).
REQ-013 len = 0 with header disabled: SHALL emit no words and go directly to S_DONE.
REQ-014 S_DONE: SHALL assert done for exactly one cycle, then enter S_HOLDOFF.
REQ-015 S_HOLDOFF: SHALL wait 3 cycles ignoring rd_busy, then return to S_IDLE. This covers the double buffer clearing busy and advancing its read index.
REQ-016 active SHALL be 1 in every state except S_IDLE.
REQ-017 Counters SHALL be 17 bits wide so that len = 2^16 cannot wrap. Addresses above 2^P_RD_ADDR_WIDTH-1 SHALL never be issued.
REQ-018 If rd_busy drops while not in S_IDLE, the block SHALL ignore it and complete the page.

Reset
REQ-019 On rst=1 the block SHALL enter S_IDLE, flush the FIFO and in-flight tracking, and clear all counters.
REQ-020 During reset, outputs SHALL be: done=0, dout_valid=0, dout_last=0, active=0, rd_addr=0, dout=0.
REQ-021 Reset mid-page SHALL abandon the page without pulsing done.

Configuration
REQ-022 Macro DBUF_RDR_HEADER_EN defined: S_HDR SHALL push one header word {zero pad, len[15:0]} into the FIFO before any payload, then go to S_READ. Total words = len+1. With len=0, the header alone SHALL carry dout_last=1.
REQ-023 Macro DBUF_RDR_HEADER_EN undefined: S_HDR logic SHALL be absent and total words = len.

Verification
REQ-024 Scenario: rd_busy=1, dpram_len=4, dout_ready=1, header off, DPRAM holds 0xA0..0xA3 -> 4 consecutive transfers 0xA0..0xA3, dout_last on 0xA3, done pulses once.
REQ-025 Scenario: dpram_len=16, dout_ready toggling 1/0 each cycle, P_RD_LATENCY=2 -> all 16 words in address order, no gaps in data, stable while stalled.
REQ-026 Scenario: dpram_len=0, header off -> no dout_valid, done pulse within 3 cycles of rd_busy rising.
REQ-027 Scenario: dpram_len=700, P_RD_ADDR_WIDTH=9 -> exactly 512 words, max rd_addr=511, dout_last on the 512th word.
REQ-028 Scenario: header on, dpram_len=2 -> words 0x0002, D0, D1, dout_last on D1.
REQ-029 Scenario: rst asserted after 3 of 8 words -> outputs return to reset values next cycle, no done pulse; the next page starts at rd_addr=0.

Source files
------------

// File: rtl/dbuf_page_reader.sv
// Streams one double-buffer page from the DPRAM read port onto a valid/ready interface.
// Define DBUF_RDR_HEADER_EN to prepend a header word carrying the page length.
module dbuf_page_reader #(
  parameter int unsigned P_RD_ADDR_WIDTH = 9,
  parameter int unsigned P_DATA_WIDTH    = 64,
  parameter int unsigned P_RD_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_busy,
  input  logic [15:0]                dpram_len,
  output logic [P_RD_ADDR_WIDTH-1:0] rd_addr,
  input  logic [P_DATA_WIDTH-1:0]    rd_dout,
  output logic                       done,
  output logic [P_DATA_WIDTH-1:0]    dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
  output logic                       active
);

  localparam logic [16:0] PageWords = 17'(2 ** P_RD_ADDR_WIDTH);
`ifdef DBUF_RDR_HEADER_EN
  localparam logic [16:0] HdrWords = 17'd1;
`else
  localparam logic [16:0] HdrWords = 17'd0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_READ, S_DRAIN, S_DONE, S_HOLDOFF} state_e;

  state_e                   state_q, state_d;
  logic [16:0]              len_q, len_d;
  logic [16:0]              issue_cnt_q, issue_cnt_d;
  logic [16:0]              xfer_cnt_q, xfer_cnt_d;
  logic [1:0]               hold_q, hold_d;
  logic [P_RD_LATENCY-1:0]  pipe_q, pipe_d;
  logic [P_DATA_WIDTH-1:0]  fifo_mem_q [4];
  logic [P_DATA_WIDTH-1:0]  fifo_mem_d [4];
  logic [1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]               fifo_cnt_q, fifo_cnt_d;

  logic [2:0]               inflight;
  logic                     issue, push, pop, hdr_push;
  logic [P_DATA_WIDTH-1:0]  push_data;
  logic [16:0]              req_len;

`ifdef DBUF_RDR_HEADER_EN
  assign hdr_push  = (state_q == S_HDR);
  assign push_data = hdr_push ? P_DATA_WIDTH'(len_q[15:0]) : rd_dout;
`else
  assign hdr_push  = 1'b0;
  assign push_data = rd_dout;
`endif

  // Credit check: FIFO slots already taken plus reads still on their way back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < P_RD_LATENCY; i++) inflight = inflight + 3'(pipe_q[i]);
    issue   = (state_q == S_READ) && (issue_cnt_q < len_q) && ((fifo_cnt_q + inflight) < 3'd4);
    push    = pipe_q[P_RD_LATENCY-1] || hdr_push;
    pop     = (fifo_cnt_q != 3'd0) && dout_ready;
    req_len = {1'b0, dpram_len};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_busy) begin
`ifdef DBUF_RDR_HEADER_EN
          state_d = S_HDR;
`else
          state_d = (dpram_len == 16'd0) ? S_DONE : S_READ;
`endif
        end
      end
`ifdef DBUF_RDR_HEADER_EN
      S_HDR:     state_d = S_READ;
`endif
      S_READ:    if (issue_cnt_d >= len_q) state_d = S_DRAIN;
      S_DRAIN:   if (fifo_cnt_q == 3'd0 && inflight == 3'd0) state_d = S_DONE;
      S_DONE:    state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_q == 2'd2) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (state_q == S_IDLE && rd_busy) begin
      len_d       = (req_len > PageWords) ? PageWords : req_len;
      issue_cnt_d = '0;
      xfer_cnt_d  = '0;
    end
    if (issue) issue_cnt_d = issue_cnt_q + 17'd1;
    if (pop)   xfer_cnt_d  = xfer_cnt_q + 17'd1;
    hold_d = (state_q == S_HOLDOFF) ? hold_q + 2'd1 : 2'd0;

    pipe_d[0] = issue;
    for (int i = 1; i < P_RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      hold_q      <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      hold_q      <= hold_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // dout is masked so stale FIFO contents never show while nothing is valid.
  always_comb begin
    done       = (state_q == S_DONE);
    active     = (state_q != S_IDLE);
    dout_valid = (fifo_cnt_q != 3'd0);
    dout       = dout_valid ? fifo_mem_q[rd_ptr_q] : '0;
    dout_last  = dout_valid && ((xfer_cnt_q + 17'd1) == (len_q + HdrWords));
    rd_addr    = issue_cnt_q[P_RD_ADDR_WIDTH-1:0];
  end

endmodule

// File: tb/tb_dbuf_page_reader.sv
// Self-checking bench for dbuf_page_reader: DPRAM model plus a word-list reference per page.
module tb_dbuf_page_reader;
  localparam int AW   = 9;
  localparam int DW   = 64;
  localparam int LAT  = 2;
  localparam int PAGE = 1 << AW;
`ifdef DBUF_RDR_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_busy;
  logic [15:0]   dpram_len;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dout;
  logic          done;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          active;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem     [PAGE];
  logic [DW-1:0] rd_pipe [LAT];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_pipe[0] <= mem[rd_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_dout = rd_pipe[LAT-1];

  dbuf_page_reader #(
    .P_RD_ADDR_WIDTH(AW),
    .P_DATA_WIDTH   (DW),
    .P_RD_LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_busy   (rd_busy),
    .dpram_len (dpram_len),
    .rd_addr   (rd_addr),
    .rd_dout   (rd_dout),
    .done      (done),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .active    (active)
  );

  // mode: 0 = ready held high, 1 = ready toggles each cycle, 2 = random ready
  task automatic run_page(input string name, input int len, input int mode, input bit drop_busy);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          lst_q[$];
    int n, exp_n, limit, done_cnt, done_at, first_v, first_px, last_x;
    int stall_bad, max_addr, addr0, data_bad, bad_i, last_bad;
    logic act3, act4, pv, pr, pl;
    logic [DW-1:0] pd;
    n = (len > PAGE) ? PAGE : len;
    for (int i = 0; i < HDR; i++) exp_q.push_back(DW'(16'(n)));
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    exp_n = exp_q.size();
    limit = 12 * exp_n + 40;
    done_cnt = 0; done_at = -1; first_v = -1; first_px = -1; last_x = -1;
    stall_bad = 0; max_addr = 0; addr0 = -1;
    act3 = 1'bx; act4 = 1'bx; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    @(negedge clk);
    dpram_len = 16'(len);
    rd_busy   = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = cyc[0];
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (drop_busy && cyc == 3) begin
        rd_busy   = 1'b0;
        dpram_len = 16'($urandom);
      end
      #1;
      if (cyc == 1) addr0 = int'(rd_addr);
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (pv && !pr && (dout_valid !== 1'b1 || dout !== pd || dout_last !== pl)) stall_bad++;
      if (dout_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (dout_valid === 1'b1 && dout_ready) begin
        got_q.push_back(dout);
        lst_q.push_back(dout_last);
        if (got_q.size() == HDR + 1) first_px = cyc;
        last_x = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = cyc;
          rd_busy = 1'b0;
        end
      end
      if (done_at >= 0 && cyc == done_at + 3) act3 = active;
      if (done_at >= 0 && cyc == done_at + 4) begin
        act4 = active;
        break;
      end
      pv = dout_valid; pr = dout_ready; pd = dout; pl = dout_last;
    end

    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL %s.timeout: no done within %0d cycles, required a done pulse", name, limit);
    end
    total++;
    if (got_q.size() != exp_n) begin
      bad++;
      $display("FAIL %s.count: got %0d words, required %0d", name, got_q.size(), exp_n);
    end
    data_bad = 0; bad_i = -1;
    for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        data_bad++;
        if (bad_i < 0) bad_i = i;
      end
    end
    total++;
    if (data_bad != 0) begin
      bad++;
      $display("FAIL %s.data: word %0d got %h, required %h (%0d wrong)", name, bad_i,
               got_q[bad_i], exp_q[bad_i], data_bad);
    end
    last_bad = 0;
    for (int i = 0; i < lst_q.size(); i++) if (lst_q[i] !== 1'(i == exp_n - 1)) last_bad++;
    total++;
    if (last_bad != 0) begin
      bad++;
      $display("FAIL %s.last: %0d words with wrong dout_last, required 0", name, last_bad);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s.done: %0d done pulses, required 1", name, done_cnt);
    end
    total++;
    if (act3 !== 1'b1 || act4 !== 1'b0) begin
      bad++;
      $display("FAIL %s.holdoff: active %b/%b at done+3/+4, required 1/0", name, act3, act4);
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL %s.stall: output changed during stall %0d times, required 0", name, stall_bad);
    end
    total++;
    if (addr0 != 0) begin
      bad++;
      $display("FAIL %s.start_addr: rd_addr %0d at page start, required 0", name, addr0);
    end
    if (exp_n == 0) begin
      total++;
      if (first_v >= 0 || done_at > 3 || done_at < 0) begin
        bad++;
        $display("FAIL %s.empty: first valid %0d done at %0d, required no valid and done<=3",
                 name, first_v, done_at);
      end
    end
    if (mode == 0 && n > 0) begin
      total++;
      if (first_px < 0 || first_px > LAT + 2 + HDR) begin
        bad++;
        $display("FAIL %s.latency: first payload at cycle %0d, required <= %0d", name,
                 first_px, LAT + 2 + HDR);
      end
      total++;
      if (last_x - first_px + 1 != n) begin
        bad++;
        $display("FAIL %s.throughput: payload spans %0d cycles, required %0d", name,
                 last_x - first_px + 1, n);
      end
    end
    if (n == PAGE) begin
      total++;
      if (max_addr != PAGE - 1) begin
        bad++;
        $display("FAIL %s.max_addr: %0d, required %0d", name, max_addr, PAGE - 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({done, dout_valid, dout_last, active} !== 4'b0000) begin
      bad++;
      $display("FAIL reset.ctrl: done/valid/last/active=%b, required 0000",
               {done, dout_valid, dout_last, active});
    end
    total++;
    if (rd_addr !== '0) begin
      bad++;
      $display("FAIL reset.rd_addr: %0d, required 0", rd_addr);
    end
    total++;
    if (dout !== '0) begin
      bad++;
      $display("FAIL reset.dout: %h, required 0", dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'hA0 + i);
    run_page("basic", 4, 0, 1'b0);
  endtask

  task automatic test_stall_toggle;
    run_page("toggle16", 16, 1, 1'b0);
  endtask

  task automatic test_zero_len;
    run_page("zero_len", 0, 0, 1'b0);
  endtask

  task automatic test_clamp;
    run_page("clamp700", 700, 0, 1'b0);
  endtask

  task automatic test_len2;
    run_page("len2", 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid_page;
    int  xfers;
    bit  done_seen, fired;
    xfers = 0; done_seen = 1'b0; fired = 1'b0;
    @(negedge clk);
    dpram_len  = 16'd8;
    rd_busy    = 1'b1;
    dout_ready = 1'b1;
    for (int cyc = 1; cyc <= 40 && !fired; cyc++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) done_seen = 1'b1;
      if (xfers == 3) begin
        rst     = 1'b1;
        rd_busy = 1'b0;
        fired   = 1'b1;
      end else if (dout_valid === 1'b1 && dout_ready) begin
        xfers++;
      end
    end
    total++;
    if (!fired) begin
      bad++;
      $display("FAIL midrst.timeout: %0d words seen, required 3 before reset", xfers);
    end
    @(negedge clk);
    #1;
    if (done === 1'b1) done_seen = 1'b1;
    total++;
    if ({dout_valid, dout_last, active} !== 3'b000 || rd_addr !== '0 || dout !== '0) begin
      bad++;
      $display("FAIL midrst.outputs: valid/last/active=%b rd_addr=%0d dout=%h, required 000/0/0",
               {dout_valid, dout_last, active}, rd_addr, dout);
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL midrst.done: done pulsed, required none");
    end
    rst = 1'b0;
    @(negedge clk);
    run_page("after_reset", 8, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = DW'({$urandom, $urandom});
      run_page("random", int'($urandom_range(1, 40)), (r % 2) + 1, 1'(r == 2 || r == 5));
    end
    run_page("random_len0_drop", 0, 2, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    rd_busy    = 1'b0;
    dpram_len  = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < PAGE; i++) mem[i] = DW'({$urandom, $urandom});
    test_reset();
    test_basic();
    test_stall_toggle();
    test_zero_len();
    test_clamp();
    test_len2();
    test_reset_mid_page();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
